// File: rtl/lt24_bus_monitor.sv
// Clocked LT24 8080-bus snooper: decodes window/MADCTL/RAM-write traffic and
// emits one mapped pixel strobe per accepted pixel write.
module lt24_bus_monitor #(
    parameter int unsigned WIDTH       = 240,
    parameter int unsigned HEIGHT      = 320,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FRAME_CNT_W = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   LT24Wr_n,
    input  logic                   LT24CS_n,
    input  logic                   LT24RS,
    input  logic                   LT24Reset_n,
    input  logic [15:0]            LT24Data,
    output logic                   pixel_valid,
    output logic [15:0]            pixel_x,
    output logic [15:0]            pixel_y,
    output logic [15:0]            pixel_colour,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   protocol_error
);
    localparam int unsigned DataW  = 16;
    localparam int unsigned Last   = SYNC_STAGES - 1;
    localparam logic [15:0] PanelW = 16'(WIDTH);
    localparam logic [15:0] PanelH = 16'(HEIGHT);
    localparam logic [15:0] XMaxRst = 16'(WIDTH - 1);
    localparam logic [15:0] YMaxRst = 16'(HEIGHT - 1);

    typedef enum logic [2:0] {
        stIdle, stMadctl, stCaset, stPaset, stRamwr, stRamwrc, stOther
    } cmdState_t;

    // Bus synchronisers; Wr_n idles high so reset it high to avoid a false edge.
    logic [SYNC_STAGES-1:0] wrSync, csSync, rsSync, rstSync;
    logic [DataW-1:0]       dataSync [SYNC_STAGES];
    logic                   wrDly;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrSync  <= '1;
            csSync  <= '1;
            rsSync  <= '0;
            rstSync <= '0;
            wrDly   <= 1'b1;
            for (int i = 0; i < int'(SYNC_STAGES); i++) dataSync[i] <= '0;
        end else begin
            wrSync  <= {wrSync[SYNC_STAGES-2:0], LT24Wr_n};
            csSync  <= {csSync[SYNC_STAGES-2:0], LT24CS_n};
            rsSync  <= {rsSync[SYNC_STAGES-2:0], LT24RS};
            rstSync <= {rstSync[SYNC_STAGES-2:0], LT24Reset_n};
            dataSync[0] <= LT24Data;
            for (int i = 1; i < int'(SYNC_STAGES); i++) dataSync[i] <= dataSync[i-1];
            wrDly   <= wrSync[Last];
        end
    end

    logic             wrEvent, softRst, busRs;
    logic [DataW-1:0] busData;

    assign wrEvent = !wrDly && wrSync[Last] && !csSync[Last];
    assign softRst = !rstSync[Last];
    assign busRs   = rsSync[Last];
    assign busData = dataSync[Last];

    cmdState_t        state, stateNext;
    logic [7:0]       madctl, madctlNext;
    logic [15:0]      cfgXMin, cfgXMax, cfgYMin, cfgYMax;
    logic [15:0]      cfgXMinNext, cfgXMaxNext, cfgYMinNext, cfgYMaxNext;
    logic [15:0]      winXMin, winXMax, winYMin, winYMax;
    logic [15:0]      winXMinNext, winXMaxNext, winYMinNext, winYMaxNext;
    logic [15:0]      xPtr, yPtr, xPtrNext, yPtrNext;
    logic [2:0]       payCnt, payCntNext;
    logic             pixelValidNext, frameDoneNext, protoErrNext;
    logic [15:0]      pixelXNext, pixelYNext, pixelColourNext;
    logic [FRAME_CNT_W-1:0] frameCountNext;
    logic [15:0]      rawX, rawY;
    logic [DataW-1:0] revData;
    logic             winOk;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= stIdle;
            madctl         <= '0;
            cfgXMin        <= '0;
            cfgXMax        <= XMaxRst;
            cfgYMin        <= '0;
            cfgYMax        <= YMaxRst;
            winXMin        <= '0;
            winXMax        <= XMaxRst;
            winYMin        <= '0;
            winYMax        <= YMaxRst;
            xPtr           <= '0;
            yPtr           <= '0;
            payCnt         <= '0;
            pixel_valid    <= 1'b0;
            pixel_x        <= '0;
            pixel_y        <= '0;
            pixel_colour   <= '0;
            frame_done     <= 1'b0;
            frame_count    <= '0;
            protocol_error <= 1'b0;
        end else begin
            state          <= stateNext;
            madctl         <= madctlNext;
            cfgXMin        <= cfgXMinNext;
            cfgXMax        <= cfgXMaxNext;
            cfgYMin        <= cfgYMinNext;
            cfgYMax        <= cfgYMaxNext;
            winXMin        <= winXMinNext;
            winXMax        <= winXMaxNext;
            winYMin        <= winYMinNext;
            winYMax        <= winYMaxNext;
            xPtr           <= xPtrNext;
            yPtr           <= yPtrNext;
            payCnt         <= payCntNext;
            pixel_valid    <= pixelValidNext;
            pixel_x        <= pixelXNext;
            pixel_y        <= pixelYNext;
            pixel_colour   <= pixelColourNext;
            frame_done     <= frameDoneNext;
            frame_count    <= frameCountNext;
            protocol_error <= protoErrNext;
        end
    end

    // Command decode, window programming and pixel pointer walk.
    always_comb begin
        stateNext       = state;
        madctlNext      = madctl;
        cfgXMinNext     = cfgXMin;
        cfgXMaxNext     = cfgXMax;
        cfgYMinNext     = cfgYMin;
        cfgYMaxNext     = cfgYMax;
        winXMinNext     = winXMin;
        winXMaxNext     = winXMax;
        winYMinNext     = winYMin;
        winYMaxNext     = winYMax;
        xPtrNext        = xPtr;
        yPtrNext        = yPtr;
        payCntNext      = payCnt;
        pixelValidNext  = 1'b0;
        frameDoneNext   = 1'b0;
        pixelXNext      = pixel_x;
        pixelYNext      = pixel_y;
        pixelColourNext = pixel_colour;
        frameCountNext  = frame_count;
        protoErrNext    = protocol_error;

        winOk = (cfgXMin <= cfgXMax) && (cfgYMin <= cfgYMax);
        rawX  = madctl[5] ? (yPtr % PanelW) : (xPtr % PanelW);
        rawY  = madctl[5] ? (xPtr % PanelH) : (yPtr % PanelH);
        for (int unsigned i = 0; i < DataW; i++) revData[i] = busData[DataW-1-i];

        if (softRst) begin
            stateNext       = stIdle;
            madctlNext      = '0;
            cfgXMinNext     = '0;
            cfgXMaxNext     = XMaxRst;
            cfgYMinNext     = '0;
            cfgYMaxNext     = YMaxRst;
            winXMinNext     = '0;
            winXMaxNext     = XMaxRst;
            winYMinNext     = '0;
            winYMaxNext     = YMaxRst;
            xPtrNext        = '0;
            yPtrNext        = '0;
            payCntNext      = '0;
            pixelXNext      = '0;
            pixelYNext      = '0;
            pixelColourNext = '0;
            frameCountNext  = '0;
            protoErrNext    = 1'b0;
        end else if (wrEvent) begin
            if (!busRs) begin
                payCntNext = '0;
                case (busData[7:0])
                    8'h36: stateNext = stMadctl;
                    8'h2A: stateNext = stCaset;
                    8'h2B: stateNext = stPaset;
                    8'h2C, 8'h3C: begin
                        stateNext = (busData[7:0] == 8'h2C) ? stRamwr : stRamwrc;
                        // A bad window is flagged and the active window kept.
                        if (winOk) begin
                            winXMinNext = cfgXMin;
                            winXMaxNext = cfgXMax;
                            winYMinNext = cfgYMin;
                            winYMaxNext = cfgYMax;
                        end else begin
                            protoErrNext = 1'b1;
                        end
                        if (busData[7:0] == 8'h2C) begin
                            xPtrNext = winOk ? cfgXMin : winXMin;
                            yPtrNext = winOk ? cfgYMin : winYMin;
                        end
                    end
                    default: stateNext = stOther;
                endcase
            end else begin
                if (payCnt != 3'd4) payCntNext = payCnt + 3'd1;
                case (state)
                    stIdle:   protoErrNext = 1'b1;
                    stMadctl: madctlNext = busData[7:0];
                    stCaset: begin
                        case (payCnt)
                            3'd0:    cfgXMinNext[15:8] = busData[7:0];
                            3'd1:    cfgXMinNext[7:0]  = busData[7:0];
                            3'd2:    cfgXMaxNext[15:8] = busData[7:0];
                            3'd3:    cfgXMaxNext[7:0]  = busData[7:0];
                            default: protoErrNext = 1'b1;
                        endcase
                    end
                    stPaset: begin
                        case (payCnt)
                            3'd0:    cfgYMinNext[15:8] = busData[7:0];
                            3'd1:    cfgYMinNext[7:0]  = busData[7:0];
                            3'd2:    cfgYMaxNext[15:8] = busData[7:0];
                            3'd3:    cfgYMaxNext[7:0]  = busData[7:0];
                            default: protoErrNext = 1'b1;
                        endcase
                    end
                    stRamwr, stRamwrc: begin
                        pixelValidNext  = 1'b1;
                        pixelXNext      = madctl[6] ? rawX : (PanelW - 16'd1) - rawX;
                        pixelYNext      = madctl[7] ? (PanelH - 16'd1) - rawY : rawY;
                        pixelColourNext = madctl[3] ? revData : busData;
                        if (xPtr == winXMax) begin
                            xPtrNext = winXMin;
                            if (yPtr == winYMax) begin
                                yPtrNext       = winYMin;
                                frameDoneNext  = 1'b1;
                                frameCountNext = frame_count + FRAME_CNT_W'(1);
                            end else begin
                                yPtrNext = yPtr + 16'd1;
                            end
                        end else begin
                            xPtrNext = xPtr + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lt24_bus_monitor.sv
// Self-checking bench for lt24_bus_monitor: directed steps plus randomized
// window/pixel traffic scored against a pixel-index reference model.
module tb_lt24_bus_monitor;
    localparam int unsigned WIDTH       = 240;
    localparam int unsigned HEIGHT      = 320;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned FRAME_CNT_W = 8;
    localparam int          StrobeEdge  = int'(SYNC_STAGES) + 1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        LT24Wr_n = 1'b1;
    logic        LT24CS_n = 1'b1;
    logic        LT24RS = 1'b0;
    logic        LT24Reset_n = 1'b1;
    logic [15:0] LT24Data = '0;
    logic        pixel_valid;
    logic [15:0] pixel_x, pixel_y, pixel_colour;
    logic        frame_done;
    logic [FRAME_CNT_W-1:0] frame_count;
    logic        protocol_error;

    always #5 clock = ~clock;

    lt24_bus_monitor #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .SYNC_STAGES(SYNC_STAGES), .FRAME_CNT_W(FRAME_CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .LT24Wr_n(LT24Wr_n), .LT24CS_n(LT24CS_n),
        .LT24RS(LT24RS), .LT24Reset_n(LT24Reset_n), .LT24Data(LT24Data),
        .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pixel_colour(pixel_colour), .frame_done(frame_done),
        .frame_count(frame_count), .protocol_error(protocol_error)
    );

    int nCompared = 0;
    int nMismatched = 0;

    // What the last bus write produced on the strobe outputs.
    int          vCount, vEdge;
    logic [15:0] vX, vY, vCol;
    logic        vFd;

    // Reference model: programmed and active window, pixel index within the stream.
    int          mCmd;
    int          mPay;
    logic [7:0]  mMadctl;
    logic [15:0] cXMin, cXMax, cYMin, cYMax;
    logic [15:0] aXMin, aXMax, aYMin, aYMax;
    longint      mIdx;
    logic        mErr;
    logic [7:0]  mFrames;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mCmd = -1; mPay = 0; mMadctl = '0; mIdx = 0; mErr = 1'b0; mFrames = '0;
        cXMin = '0; cXMax = 16'(WIDTH - 1); cYMin = '0; cYMax = 16'(HEIGHT - 1);
        aXMin = cXMin; aXMax = cXMax; aYMin = cYMin; aYMax = cYMax;
    endtask

    task automatic checkZero(input string tag);
        check({tag, "_valid"}, 32'(pixel_valid), 0);
        check({tag, "_x"}, 32'(pixel_x), 0);
        check({tag, "_y"}, 32'(pixel_y), 0);
        check({tag, "_colour"}, 32'(pixel_colour), 0);
        check({tag, "_fdone"}, 32'(frame_done), 0);
        check({tag, "_fcount"}, 32'(frame_count), 0);
        check({tag, "_perr"}, 32'(protocol_error), 0);
    endtask

    task automatic checkStatus(input string tag);
        check({tag, "_perr"}, 32'(protocol_error), 32'(mErr));
        check({tag, "_fcount"}, 32'(frame_count), 32'(mFrames));
    endtask

    task automatic hardReset();
        @(negedge clock); reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (SYNC_STAGES + 2) @(negedge clock);
        modelReset();
    endtask

    // One full bus write; records every strobe seen and on which edge after Wr_n rose.
    task automatic busWrite(input logic rs, input logic [15:0] d, input logic csN);
        vCount = 0; vEdge = 0;
        @(negedge clock);
        LT24CS_n = csN; LT24RS = rs; LT24Data = d; LT24Wr_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            if (pixel_valid) begin vCount++; vEdge = -1; end
        end
        @(negedge clock);
        LT24Wr_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clock); #1;
            if (pixel_valid) begin
                vCount++; vEdge = k;
                vX = pixel_x; vY = pixel_y; vCol = pixel_colour; vFd = frame_done;
            end
        end
    endtask

    task automatic cmd(input logic [7:0] c);
        busWrite(1'b0, {8'($urandom), c}, 1'b0);
        check("cmd_no_strobe", 32'(vCount), 0);
        mPay = 0; mCmd = int'(c);
        if (c == 8'h2C || c == 8'h3C) begin
            if (cXMin <= cXMax && cYMin <= cYMax) begin
                aXMin = cXMin; aXMax = cXMax; aYMin = cYMin; aYMax = cYMax;
            end else begin
                mErr = 1'b1;
            end
            if (c == 8'h2C) mIdx = 0;
        end
        checkStatus("cmd");
    endtask

    task automatic payload(input logic [15:0] d);
        longint w, h, n;
        int x, y, rx, ry;
        logic [15:0] ecol;
        busWrite(1'b1, d, 1'b0);
        if (mCmd == 'h2C || mCmd == 'h3C) begin
            w = longint'(aXMax) - longint'(aXMin) + 1;
            h = longint'(aYMax) - longint'(aYMin) + 1;
            n = mIdx % (w * h);
            x = int'(aXMin) + int'(n % w);
            y = int'(aYMin) + int'(n / w);
            rx = (mMadctl[5] ? y : x) % int'(WIDTH);
            ry = (mMadctl[5] ? x : y) % int'(HEIGHT);
            if (mMadctl[3]) ecol = {<<{d}};
            else ecol = d;
            check("px_count", 32'(vCount), 1);
            check("px_latency", 32'(vEdge), 32'(StrobeEdge));
            check("px_x", 32'(vX), 32'(mMadctl[6] ? rx : int'(WIDTH) - 1 - rx));
            check("px_y", 32'(vY), 32'(mMadctl[7] ? int'(HEIGHT) - 1 - ry : ry));
            check("px_colour", 32'(vCol), 32'(ecol));
            check("px_fdone", 32'(vFd), 32'(n == w * h - 1));
            if (n == w * h - 1) mFrames++;
            mIdx++;
        end else begin
            check("pay_no_strobe", 32'(vCount), 0);
            case (mCmd)
                -1:    mErr = 1'b1;
                'h36:  mMadctl = d[7:0];
                'h2A, 'h2B: begin
                    if (mPay >= 4) mErr = 1'b1;
                    else if (mCmd == 'h2A) begin
                        case (mPay)
                            0: cXMin[15:8] = d[7:0];
                            1: cXMin[7:0]  = d[7:0];
                            2: cXMax[15:8] = d[7:0];
                            default: cXMax[7:0] = d[7:0];
                        endcase
                    end else begin
                        case (mPay)
                            0: cYMin[15:8] = d[7:0];
                            1: cYMin[7:0]  = d[7:0];
                            2: cYMax[15:8] = d[7:0];
                            default: cYMax[7:0] = d[7:0];
                        endcase
                    end
                end
                default: ;
            endcase
        end
        if (mPay < 4) mPay++;
        checkStatus("pay");
    endtask

    task automatic ignoredWrite(input logic rs, input logic [15:0] d);
        busWrite(rs, d, 1'b1);
        check("cs_ignored", 32'(vCount), 0);
        checkStatus("cs_ignored");
    endtask

    task automatic setMadctl(input logic [7:0] m);
        cmd(8'h36); payload({8'($urandom), m});
    endtask

    task automatic setWindow(input logic [7:0] c, input logic [15:0] lo, input logic [15:0] hi);
        cmd(c);
        payload({8'($urandom), lo[15:8]}); payload({8'($urandom), lo[7:0]});
        payload({8'($urandom), hi[15:8]}); payload({8'($urandom), hi[7:0]});
    endtask

    initial begin
        modelReset();
        hardReset();
        checkZero("reset");

        // Payload with no command pending is a protocol error.
        payload(16'h00AA);
        check("idle_payload_err", 32'(protocol_error), 1);
        hardReset();

        // Test 1: 2x3 window walk, frame done on the last pixel.
        setMadctl(8'h40);
        setWindow(8'h2A, 16'd10, 16'd11);
        setWindow(8'h2B, 16'd20, 16'd22);
        cmd(8'h2C);
        for (int i = 1; i <= 6; i++) begin
            payload(16'(i));
            if (i == 1) begin check("t1_first_x", 32'(vX), 10); check("t1_first_y", 32'(vY), 20); end
            if (i == 5) check("t1_fd_early", 32'(vFd), 0);
            if (i == 6) begin
                check("t1_last_x", 32'(vX), 11); check("t1_last_y", 32'(vY), 22);
                check("t1_fd_last", 32'(vFd), 1);
            end
        end
        check("t1_fcount", 32'(frame_count), 1);

        // Test 2: orientation corners on the full panel.
        hardReset();
        setMadctl(8'h00); cmd(8'h2C); payload(16'h1234);
        check("t2_x0", 32'(vX), 239); check("t2_y0", 32'(vY), 0);
        setMadctl(8'hE0); cmd(8'h2C); payload(16'h1234);
        check("t2_xe", 32'(vX), 0); check("t2_ye", 32'(vY), 319);

        // Test 3: BGR bit reversal.
        setMadctl(8'h48); cmd(8'h2C); payload(16'h0001);
        check("t3_rev", 32'(vCol), 32'h8000);
        setMadctl(8'h40); cmd(8'h2C); payload(16'hF800);
        check("t3_plain", 32'(vCol), 32'hF800);

        // Test 4: RAMWRC continues the stream, RAMWR restarts it.
        setWindow(8'h2A, 16'd10, 16'd11);
        setWindow(8'h2B, 16'd20, 16'd22);
        cmd(8'h2C);
        for (int i = 0; i < 3; i++) payload(16'($urandom));
        cmd(8'h3C);
        payload(16'($urandom));
        check("t4_cont_x", 32'(vX), 11); check("t4_cont_y", 32'(vY), 21);
        payload(16'($urandom)); payload(16'($urandom));
        check("t4_cont_fd", 32'(vFd), 1);
        cmd(8'h2C);
        for (int i = 0; i < 3; i++) payload(16'($urandom));
        cmd(8'h2C);
        payload(16'($urandom));
        check("t4_restart_x", 32'(vX), 10); check("t4_restart_y", 32'(vY), 20);

        // Test 5a: fifth CASET payload is an error and leaves the window alone.
        hardReset();
        setMadctl(8'h40);
        setWindow(8'h2A, 16'd10, 16'd11);
        payload(16'h0055);
        check("t5_extra_err", 32'(protocol_error), 1);
        setWindow(8'h2B, 16'd20, 16'd22);
        cmd(8'h2C); payload(16'h0001); payload(16'h0002); payload(16'h0003);
        check("t5_win_kept_x", 32'(vX), 10); check("t5_win_kept_y", 32'(vY), 21);

        // Test 5b: inverted window is rejected and the old window is reused.
        hardReset();
        setMadctl(8'h40);
        setWindow(8'h2A, 16'd10, 16'd11);
        setWindow(8'h2B, 16'd20, 16'd22);
        cmd(8'h2C); payload(16'h0001);
        check("t5_no_err_yet", 32'(protocol_error), 0);
        setWindow(8'h2A, 16'd20, 16'd10);
        cmd(8'h2C);
        check("t5_bad_win_err", 32'(protocol_error), 1);
        payload(16'h0002);
        check("t5_old_win_x", 32'(vX), 10); check("t5_old_win_y", 32'(vY), 20);
        payload(16'h0003);
        ignoredWrite(1'b1, 16'hBEEF);
        ignoredWrite(1'b0, 16'h002C);
        payload(16'h0004);
        check("t5_after_cs_x", 32'(vX), 10); check("t5_after_cs_y", 32'(vY), 21);

        // 1x1 window: every pixel completes a frame, counter wraps.
        setWindow(8'h2A, 16'd5, 16'd5);
        setWindow(8'h2B, 16'd3, 16'd3);
        cmd(8'h2C);
        for (int i = 0; i < 257; i++) payload(16'($urandom));

        // Randomized window/orientation/stream traffic.
        for (int it = 0; it < 16; it++) begin
            logic [15:0] xl, yl;
            int w, h;
            if ($urandom_range(0, 1) == 1) setMadctl(8'($urandom));
            xl = 16'($urandom_range(0, 250)); w = int'($urandom_range(1, 4));
            yl = 16'($urandom_range(0, 330)); h = int'($urandom_range(1, 4));
            if ($urandom_range(0, 5) == 0) setWindow(8'h2A, xl + 16'd3, xl);
            else setWindow(8'h2A, xl, xl + 16'(w - 1));
            setWindow(8'h2B, yl, yl + 16'(h - 1));
            cmd(8'h2C);
            for (int p = 0; p < int'($urandom_range(1, 10)); p++) begin
                if ($urandom_range(0, 3) == 0) ignoredWrite(1'b1, 16'($urandom));
                payload(16'($urandom));
            end
            if ($urandom_range(0, 1) == 1) begin
                cmd(8'h3C);
                for (int p = 0; p < int'($urandom_range(1, 8)); p++) payload(16'($urandom));
            end
            if ($urandom_range(0, 3) == 0) begin
                cmd(8'h11); payload(16'($urandom));
            end
        end

        // Test 6: soft reset arriving with a pixel edge drops that pixel.
        setWindow(8'h2A, 16'd10, 16'd11);
        payload(16'h0077);
        setWindow(8'h2B, 16'd20, 16'd22);
        setMadctl(8'h48);
        cmd(8'h2C);
        for (int i = 0; i < 3; i++) payload(16'($urandom));
        @(negedge clock);
        LT24CS_n = 1'b0; LT24RS = 1'b1; LT24Data = 16'h1234; LT24Wr_n = 1'b0;
        repeat (5) @(negedge clock);
        LT24Wr_n = 1'b1; LT24Reset_n = 1'b0;
        vCount = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clock); #1;
            if (pixel_valid) vCount++;
        end
        check("soft_drop", 32'(vCount), 0);
        checkZero("soft");
        @(negedge clock); LT24Reset_n = 1'b1;
        repeat (SYNC_STAGES + 4) @(negedge clock);
        modelReset();
        cmd(8'h2C); payload(16'h0001);
        check("soft_win_x", 32'(vX), 239); check("soft_win_y", 32'(vY), 0);
        check("soft_madctl", 32'(vCol), 32'h0001);
        hardReset();
        checkZero("final_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
